uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arb.sv | 119 +++++++++++
 tb/tb_uart_tx_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants plus the state encoding and round-robin helper
// used by the transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_BAUD_DIV_DEF = 434;
  localparam int UART_START_TO_DEF = 255;
  localparam int UART_TO_CNT_W     = 16;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_STROBE     = 2'd1,
    ARB_WAIT_START = 2'd2,
    ARB_WAIT_DONE  = 2'd3
  } arb_state_t;

  // Wraps an index that may exceed n by less than n back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request at or after
// last_grant+1, wrapping around the request vector.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[gi] is the requester examined gi+1 places after the last grant.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = IDX_W'(rr_wrap(int'(last_grant) + gi + 1, N_REQ));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    any   = |hit;
    index = cand[0];
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) index = cand[k];
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter letting N_REQ byte sources share one tx_uart, with a
// start-acceptance timeout so a dead transmitter cannot lock the bus.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int START_TO = UART_START_TO_DEF,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic               start_tx,
  output logic [7:0]         data_in,
  input  logic               tx_started,
  input  logic               tx_done,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id,
  output logic               err_to
);

  arb_state_t                state_reg, state_next;
  logic [UART_TO_CNT_W-1:0]  to_cnt_reg;
  logic [UART_DATA_BITS-1:0] data_reg;
  logic [IDX_W-1:0]          grant_reg, last_grant_reg;
  logic [UART_DATA_BITS-1:0] req_byte [N_REQ];
  logic                      pick_any;
  logic [IDX_W-1:0]          pick_idx;
  logic                      load_grant, release_grant;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_byte
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .any        (pick_any),
    .index      (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_IDLE;
      to_cnt_reg     <= '0;
      data_reg       <= '0;
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(N_REQ - 1);
    end else begin
      state_reg <= state_next;
      // Counter reads k in the k-th WAIT_START cycle after the strobe.
      if (state_reg == ARB_STROBE)
        to_cnt_reg <= UART_TO_CNT_W'(1);
      else if (state_reg == ARB_WAIT_START)
        to_cnt_reg <= to_cnt_reg + UART_TO_CNT_W'(1);
      else
        to_cnt_reg <= '0;
      if (load_grant) begin
        data_reg  <= req_byte[pick_idx];
        grant_reg <= pick_idx;
      end
      if (release_grant) last_grant_reg <= grant_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    start_tx      = 1'b0;
    req_ack       = '0;
    err_to        = 1'b0;
    load_grant    = 1'b0;
    release_grant = 1'b0;
    busy          = (state_reg != ARB_IDLE);
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          load_grant = 1'b1;
          state_next = ARB_STROBE;
        end
      end
      ARB_STROBE: begin
        start_tx   = 1'b1;
        state_next = ARB_WAIT_START;
      end
      ARB_WAIT_START: begin
        if (tx_started) begin
          req_ack[grant_reg] = 1'b1;
          if (tx_done) begin
            release_grant = 1'b1;
            state_next    = ARB_IDLE;
          end else begin
            state_next = ARB_WAIT_DONE;
          end
        end else if (to_cnt_reg == UART_TO_CNT_W'(START_TO)) begin
          // Releasing the grant on timeout moves priority past the stuck source.
          err_to        = 1'b1;
          release_grant = 1'b1;
          state_next    = ARB_IDLE;
        end
      end
      ARB_WAIT_DONE: begin
        if (tx_done) begin
          release_grant = 1'b1;
          state_next    = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign data_in  = data_reg;
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queued requesters, a behavioural tx_uart responder
// and a transaction-level round-robin model checked every cycle.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic           start_tx;
  logic [7:0]     data_in;
  logic           tx_started = 1'b0;
  logic           tx_done = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err_to;

  uart_tx_arb #(.N_REQ(N), .START_TO(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .start_tx(start_tx), .data_in(data_in),
    .tx_started(tx_started), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .err_to(err_to)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester byte queues and tx_uart responder controls
  logic [7:0] rq [N][$];
  int   tx_mode   = 0;   // 0: normal, 1: never starts, 2: start and done together
  int   start_dly = 1;
  int   done_dly  = 3;
  int   em_phase  = 0;
  int   em_cnt    = 0;
  bit   strobe_seen = 0;
  logic [N-1:0] ack_seen = '0;

  // Transaction-level model of the arbiter
  int         cyc = 0;
  bit         inflight = 0, acked = 0, prev_idle = 0;
  int         m_last = N - 1, m_gid = 0, g_idx = 0, strobe_cyc = 0;
  logic [7:0] m_data = 8'h00;
  logic [N-1:0]   prev_req = '0;
  logic [8*N-1:0] prev_data = '0;
  bit         exp_start, exp_err, m_done;
  logic [N-1:0] exp_ack;
  int         ei;

  // Observations of the DUT
  int         dut_acks = 0, dut_errs = 0, dut_strobe_cyc = 0, err_age = -1;
  int         log_idx [$];
  logic [7:0] log_byte [$];
  bit         seen [256];

  function automatic int rr_model(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Compare process: one pass per cycle on the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    ack_seen = req_ack;
    if (!rst_n) begin
      chk("rst_start_tx", start_tx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ack", req_ack, 0);
      chk("rst_err_to", err_to, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_data_in", data_in, 0);
      inflight = 0; acked = 0; prev_idle = 0;
      m_last = N - 1; m_gid = 0; m_data = 8'h00;
    end else begin
      exp_start = prev_idle && (prev_req != '0);
      exp_ack = '0; exp_err = 0; m_done = 0;
      if (exp_start) begin
        ei = rr_model(prev_req, m_last);
        m_gid = ei;
        m_data = prev_data[8*ei +: 8];
      end
      if (inflight && !acked) begin
        if (tx_started) begin
          exp_ack[g_idx] = 1'b1;
          if (tx_done) m_done = 1;
        end else if (cyc - strobe_cyc == TO) begin
          exp_err = 1; m_done = 1;
        end
      end else if (inflight && acked && tx_done) begin
        m_done = 1;
      end
      chk("start_tx", start_tx, exp_start);
      chk("busy", busy, inflight || exp_start);
      chk("req_ack", req_ack, exp_ack);
      chk("err_to", err_to, exp_err);
      chk("grant_id", grant_id, m_gid);
      chk("data_in", data_in, m_data);
      prev_idle = !inflight && !exp_start;
      if (exp_start) begin
        inflight = 1; acked = 0; g_idx = ei; strobe_cyc = cyc;
      end
      if (exp_ack != '0) acked = 1;
      if (m_done) begin
        inflight = 0; m_last = g_idx;
      end
    end
    if (start_tx) begin
      dut_strobe_cyc = cyc;
      log_idx.push_back(int'(grant_id));
      log_byte.push_back(data_in);
      seen[data_in] = 1;
      strobe_seen = 1;
      $display("[TB] tx cycle=%0d grant=%0d byte=0x%02h", cyc, grant_id, data_in);
    end
    if (err_to) begin
      dut_errs++;
      err_age = cyc - dut_strobe_cyc;
    end
    dut_acks += $countones(req_ack);
    prev_req  = req_valid;
    prev_data = req_data;
  end

  // Requester driver and tx_uart responder, just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    tx_started = 1'b0;
    tx_done    = 1'b0;
    if (!rst_n) begin
      em_phase = 0; strobe_seen = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (ack_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (strobe_seen) begin
        strobe_seen = 0;
        if (tx_mode != 1) begin em_phase = 1; em_cnt = start_dly; end
      end
      if (em_phase == 1) begin
        if (em_cnt <= 1) begin
          tx_started = 1'b1;
          if (tx_mode == 2) begin tx_done = 1'b1; em_phase = 0; end
          else begin em_phase = 2; em_cnt = done_dly; end
        end else em_cnt--;
      end else if (em_phase == 2) begin
        if (em_cnt <= 1) begin tx_done = 1'b1; em_phase = 0; end
        else em_cnt--;
      end
    end
    ack_seen = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = (rq[i].size() > 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    repeat (2) @(posedge clk);
    while (k < budget && !(queues_empty() && !inflight && em_phase == 0)) begin
      @(posedge clk);
      k++;
    end
    chk(name, 32'(k < budget), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  int base, a0, e0, nseen;
  logic [7:0] s2_exp [8];
  int         s3_idx [4];
  logic [7:0] s3_byte [4];

  initial begin
    s2_exp  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    s3_idx  = '{2, 0, 2, 0};
    s3_byte = '{8'hC0, 8'hE0, 8'hC1, 8'hE1};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_start_tx", start_tx, 0);
    rst_n = 1'b1;

    // Single byte from requester 0
    base = log_byte.size(); a0 = dut_acks;
    rq[0].push_back(8'hA5);
    wait_drain(200, "s1_drain");
    chk("s1_count", log_byte.size() - base, 1);
    chk("s1_byte", log_byte[base], 8'hA5);
    chk("s1_idx", log_idx[base], 0);
    chk("s1_acks", dut_acks - a0, 1);

    // All four requesting, two rounds
    do_reset();
    base = log_byte.size(); a0 = dut_acks;
    for (int i = 0; i < N; i++) begin
      rq[i].push_back(8'(8'h10 + 8'h11 * i));
      rq[i].push_back(8'(8'h54 + 8'h11 * i));
    end
    wait_drain(500, "s2_drain");
    chk("s2_count", log_byte.size() - base, 8);
    for (int j = 0; j < 8; j++) chk("s2_order", log_byte[base + j], s2_exp[j]);
    chk("s2_acks", dut_acks - a0, 8);

    // Requester 2 continuous, requester 0 joins after the first grant
    do_reset();
    base = log_byte.size();
    for (int j = 0; j < 4; j++) rq[2].push_back(8'(8'hC0 + j));
    for (int k = 0; k < 100 && log_byte.size() == base; k++) @(posedge clk);
    #2;
    rq[0].push_back(8'hE0);
    rq[0].push_back(8'hE1);
    wait_drain(500, "s3_drain");
    for (int j = 0; j < 4; j++) begin
      chk("s3_grant", log_idx[base + j], s3_idx[j]);
      chk("s3_byte", log_byte[base + j], s3_byte[j]);
    end

    // tx_uart never starts: timeout, no ack, priority moves on
    do_reset();
    tx_mode = 1;
    base = log_byte.size(); a0 = dut_acks; e0 = dut_errs;
    rq[1].push_back(8'h3C);
    fork
      wait (dut_errs != e0);
      repeat (200) @(posedge clk);
    join_any
    disable fork;
    rq[1].delete();
    tx_mode = 0;
    chk("s4_err_count", dut_errs - e0, 1);
    chk("s4_err_age", err_age, 16);
    chk("s4_no_ack", dut_acks - a0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("s4_idle", busy, 0);
    base = log_byte.size();
    rq[1].push_back(8'h11);
    rq[2].push_back(8'h22);
    wait_drain(300, "s4_drain");
    chk("s4_next_grant", log_idx[base], 2);
    chk("s4_then_grant", log_idx[base + 1], 1);

    // Simultaneous tx_started and tx_done
    tx_mode = 2;
    base = log_byte.size(); a0 = dut_acks;
    rq[3].push_back(8'h7E);
    wait_drain(200, "s4b_drain");
    chk("s4b_byte", log_byte[base], 8'h7E);
    chk("s4b_acks", dut_acks - a0, 1);
    tx_mode = 0;

    // Reset during WAIT_DONE, then normal service
    do_reset();
    done_dly = 20;
    base = log_byte.size(); a0 = dut_acks;
    rq[3].push_back(8'h99);
    fork
      wait (dut_acks != a0);
      repeat (100) @(posedge clk);
    join_any
    disable fork;
    chk("s5_first_grant", log_idx[base], 3);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_data_in", data_in, 0);
    chk("s5_rst_grant_id", grant_id, 0);
    chk("s5_rst_ack", req_ack, 0);
    for (int i = 0; i < N; i++) rq[i].delete();
    a0 = dut_acks;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    done_dly = 3;
    repeat (5) @(posedge clk);
    chk("s5_no_extra_ack", dut_acks - a0, 0);
    #2;
    base = log_byte.size();
    rq[1].push_back(8'h5A);
    wait_drain(200, "s5_drain");
    chk("s5_after_grant", log_idx[base], 1);
    chk("s5_after_byte", log_byte[base], 8'h5A);

    // Every byte value on random requesters with random gaps
    do_reset();
    for (int b = 0; b < 256; b++) seen[b] = 0;
    base = log_byte.size(); a0 = dut_acks;
    for (int b = 0; b < 256; b++) begin
      rq[$urandom_range(0, N - 1)].push_back(8'(b));
      repeat ($urandom_range(1, 100)) @(posedge clk);
      #2;
    end
    wait_drain(20000, "s6_drain");
    nseen = 0;
    for (int b = 0; b < 256; b++) nseen += int'(seen[b]);
    chk("s6_count", log_byte.size() - base, 256);
    chk("s6_acks", dut_acks - a0, 256);
    chk("s6_all_values", nseen, 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
